// File: rtl/pll_lock_sequencer_if.sv
// PLL sequencer signal bundle: LOCK in, PLL reset / downstream reset out.
// Optional statistics counters appear when PLL_LOCK_SEQ_STATS_EN is defined.
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       pll_rst;
    logic       out_reset;
    logic       ready;
    logic [1:0] state;
`ifdef PLL_LOCK_SEQ_STATS_EN
    logic [7:0] retry_cnt;
    logic [7:0] lossed_cnt;

    modport master (
        input  pll_lock,
        output pll_rst, out_reset, ready, state,
        output retry_cnt, lossed_cnt
    );
    modport slave (
        output pll_lock,
        input  pll_rst, out_reset, ready, state,
        input  retry_cnt, lossed_cnt
    );
`else
    modport master (
        input  pll_lock,
        output pll_rst, out_reset, ready, state
    );
    modport slave (
        output pll_lock,
        input  pll_rst, out_reset, ready, state
    );
`endif
endinterface

// File: rtl/pll_lock_sequencer.sv
// HDMI PLL bring-up: pulse PLL reset, wait for and qualify LOCK, release video reset.
// Define PLL_LOCK_SEQ_STATS_EN to add saturating retry/lock-loss counters.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int STABLE_CYCLES = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int CNT_W         = 17
) (
    input  logic                 clk27,
    input  logic                 reset,
    pll_lock_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pll_rst;
    logic             r_out_reset;
    logic             r_ready;
    logic             w_lock_s;

    assign w_lock_s = r_sync2;

    // pll_lock is asynchronous to clk27
    always_ff @(posedge clk27) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk27) begin
        if (reset) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_out_reset <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            unique case (r_state)
                S_PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state   <= S_PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STB_LAST) begin
                        r_state     <= S_RUN;
                        r_cnt       <= '0;
                        r_out_reset <= 1'b0;
                        r_ready     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    r_cnt <= '0;
                    if (!w_lock_s) begin
                        r_state     <= S_WAIT_LOCK;
                        r_out_reset <= 1'b1;
                        r_ready     <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_PLL_RST;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.pll_rst   = r_pll_rst;
    assign bus.out_reset = r_out_reset;
    assign bus.ready     = r_ready;
    assign bus.state     = r_state;

`ifdef PLL_LOCK_SEQ_STATS_EN
    logic [7:0] r_retry_cnt;
    logic [7:0] r_lossed_cnt;
    logic       w_retry;
    logic       w_loss;

    assign w_retry = (r_state == S_WAIT_LOCK) && !w_lock_s
                     && (r_cnt == TO_LAST);
    assign w_loss  = (r_state == S_RUN) && !w_lock_s;

    always_ff @(posedge clk27) begin
        if (reset) begin
            r_retry_cnt  <= '0;
            r_lossed_cnt <= '0;
        end else begin
            if (w_retry && r_retry_cnt != 8'hFF)
                r_retry_cnt <= r_retry_cnt + 1'b1;
            if (w_loss && r_lossed_cnt != 8'hFF)
                r_lossed_cnt <= r_lossed_cnt + 1'b1;
        end
    end

    assign bus.retry_cnt  = r_retry_cnt;
    assign bus.lossed_cnt = r_lossed_cnt;
`endif

endmodule
